// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit: fetch T0-T2, execute T3-T6, halt
// Decodes the state register and IR into every datapath control strobe.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [31:0]     IR,
  input  logic            MemRdy,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            ZLOout,
  output logic            ZHIout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  ALUop,
  output logic            Run
);

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  logic [3:0]     state;
  logic [3:0]     state_nxt;
  logic           t1_first;
  logic [OPW-1:0] opcode;
  logic [3:0]     ra;
  logic [3:0]     rb;
  logic [3:0]     rc;
  logic           is_alu3;
  logic           is_muldiv;
  logic           is_halt;
  logic           unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu3   = (opcode >= OPW'(3)) && (opcode <= OPW'(8));
  assign is_muldiv = (opcode == OPW'(15)) || (opcode == OPW'(16));
  assign is_halt   = (opcode == OPW'(27));

  function automatic logic [NREG-1:0] one_hot(input logic [3:0] idx);
    return NREG'(1) << idx;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = MemRdy ? ST_T2 : ST_T1;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        if (is_alu3 || is_muldiv) state_nxt = ST_T4;
        else if (is_halt)         state_nxt = ST_HALT;
        else                      state_nxt = ST_T0;
      end
      ST_T4:   state_nxt = (is_alu3 || is_muldiv) ? ST_T5 : ST_T0;
      ST_T5:   state_nxt = is_muldiv ? ST_T6 : ST_T0;
      ST_T6:   state_nxt = ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST;
    endcase
  end

  // T1 is only entered from T0, so the flag marks the first T1 cycle of a stall.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_RST;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      t1_first <= (state == ST_T0);
    end
  end

  always_comb begin
    PCout  = 1'b0;
    MARin  = 1'b0;
    IncPC  = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    ZHIout = 1'b0;
    PCin   = 1'b0;
    Read   = 1'b0;
    MDRin  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Yin    = 1'b0;
    HIin   = 1'b0;
    LOin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    ALUop  = '0;
    Run    = (state != ST_HALT);
    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        ZLOout = 1'b1;
        PCin   = t1_first;
        Read   = 1'b1;
        MDRin  = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (is_alu3) begin
          Rout = one_hot(rb);
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Rout = one_hot(ra);
          Yin  = 1'b1;
        end
      end
      ST_T4: begin
        if (is_alu3 || is_muldiv) begin
          Rout  = is_alu3 ? one_hot(rc) : one_hot(rb);
          Zin   = 1'b1;
          ALUop = opcode;
        end
      end
      ST_T5: begin
        if (is_alu3) begin
          ZLOout = 1'b1;
          Rin    = one_hot(ra);
        end else if (is_muldiv) begin
          ZLOout = 1'b1;
          LOin   = 1'b1;
        end
      end
      ST_T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Directed vector table, hand sequences for halt/reset, and randomized instructions.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        MemRdy = 1'b1;
  logic        PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout;
  logic        IRin, Yin, HIin, LOin, Run;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALUop;
  logic [51:0] obs;

  int n_total = 0;
  int n_pass  = 0;

  control_sequencer #(.OPW(5), .NREG(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .MemRdy(MemRdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .ALUop(ALUop), .Run(Run)
  );

  always #5 Clock = ~Clock;

  assign obs = {PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin,
                MDRout, IRin, Yin, HIin, LOin, Run, ALUop, Rin, Rout};

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_ZIN    = 14'h0400;
  localparam logic [13:0] S_ZLO    = 14'h0200;
  localparam logic [13:0] S_ZHI    = 14'h0100;
  localparam logic [13:0] S_PCIN   = 14'h0080;
  localparam logic [13:0] S_READ   = 14'h0040;
  localparam logic [13:0] S_MDRIN  = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010;
  localparam logic [13:0] S_IRIN   = 14'h0008;
  localparam logic [13:0] S_YIN    = 14'h0004;
  localparam logic [13:0] S_HIIN   = 14'h0002;
  localparam logic [13:0] S_LOIN   = 14'h0001;

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic [51:0] exp;
    string       tag;
  } rec_t;

  rec_t tbl[$];

  function automatic logic [51:0] ob(input logic [13:0] s, input logic run,
                                     input logic [4:0] alu, input logic [15:0] rin,
                                     input logic [15:0] rout);
    return {s, run, alu, rin, rout};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] idx);
    logic [15:0] one;
    one = 16'h0001;
    return one << idx;
  endfunction

  task automatic add(input logic [31:0] ir, input logic mr, input logic [51:0] exp,
                     input string tag);
    rec_t r;
    r.ir = ir; r.mr = mr; r.exp = exp; r.tag = tag;
    tbl.push_back(r);
  endtask

  task automatic check(input logic [51:0] exp, input string tag);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic apply(input rec_t r);
    @(negedge Clock);
    IR = r.ir;
    MemRdy = r.mr;
    #1 check(r.exp, r.tag);
  endtask

  task automatic run_table();
    while (tbl.size() > 0) apply(tbl.pop_front());
  endtask

  // Reference model: expected per-cycle outputs of one instruction from the opcode rules.
  task automatic model_instr(input logic [31:0] ir, input int stalls, input bit rnd_mr);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    add(ir, rnd_mr ? 1'($urandom_range(0, 1)) : 1'b1,
        ob(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 1, 0, 0, 0), "m_t0");
    for (int i = 0; i <= stalls; i++)
      add(ir, (i == stalls), ob(S_ZLO | S_READ | S_MDRIN | ((i == 0) ? S_PCIN : 14'h0),
          1, 0, 0, 0), "m_t1");
    add(ir, rnd_mr ? 1'($urandom_range(0, 1)) : 1'b1, ob(S_MDROUT | S_IRIN, 1, 0, 0, 0), "m_t2");
    if (op >= 3 && op <= 8) begin
      add(ir, 1'b1, ob(S_YIN, 1, 0, 0, oh(rb)), "m_alu_t3");
      add(ir, 1'b0, ob(S_ZIN, 1, op, 0, oh(rc)), "m_alu_t4");
      add(ir, 1'b1, ob(S_ZLO, 1, 0, oh(ra), 0), "m_alu_t5");
    end else if (op == 15 || op == 16) begin
      add(ir, 1'b0, ob(S_YIN, 1, 0, 0, oh(ra)), "m_md_t3");
      add(ir, 1'b1, ob(S_ZIN, 1, op, 0, oh(rb)), "m_md_t4");
      add(ir, 1'b0, ob(S_ZLO | S_LOIN, 1, 0, 0, 0), "m_md_t5");
      add(ir, 1'b1, ob(S_ZHI | S_HIIN, 1, 0, 0, 0), "m_md_t6");
    end else begin
      add(ir, 1'b0, ob(14'h0, 1, 0, 0, 0), "m_nop_t3");
    end
  endtask

  initial begin
    logic [31:0] a_ir, m_ir, u_ir, h_ir, rnd;
    logic [51:0] f_t0, f_t1, f_t1s, f_t2, rst_o;
    logic [4:0]  op;
    a_ir  = 32'h38918000;
    m_ir  = 32'h7A100000;
    u_ir  = 32'hF8918000;
    h_ir  = 32'hD8000000;
    f_t0  = ob(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 1, 0, 0, 0);
    f_t1  = ob(S_ZLO | S_PCIN | S_READ | S_MDRIN, 1, 0, 0, 0);
    f_t1s = ob(S_ZLO | S_READ | S_MDRIN, 1, 0, 0, 0);
    f_t2  = ob(S_MDROUT | S_IRIN, 1, 0, 0, 0);
    rst_o = ob(14'h0, 1, 0, 0, 0);

    // and R1,R2,R3 without stalls
    add(a_ir, 1, f_t0, "and_t0");
    add(a_ir, 1, f_t1, "and_t1");
    add(a_ir, 1, f_t2, "and_t2");
    add(a_ir, 1, ob(S_YIN, 1, 0, 0, 16'h0004), "and_t3");
    add(a_ir, 1, ob(S_ZIN, 1, 5'b00111, 0, 16'h0008), "and_t4");
    add(a_ir, 1, ob(S_ZLO, 1, 0, 16'h0002, 0), "and_t5");
    // same with two wait states
    add(a_ir, 1, f_t0, "stall_t0");
    add(a_ir, 0, f_t1, "stall_t1a");
    add(a_ir, 0, f_t1s, "stall_t1b");
    add(a_ir, 1, f_t1s, "stall_t1c");
    add(a_ir, 1, f_t2, "stall_t2");
    add(a_ir, 1, ob(S_YIN, 1, 0, 0, 16'h0004), "stall_t3");
    add(a_ir, 1, ob(S_ZIN, 1, 5'b00111, 0, 16'h0008), "stall_t4");
    add(a_ir, 1, ob(S_ZLO, 1, 0, 16'h0002, 0), "stall_t5");
    // mul R4,R2
    add(m_ir, 1, f_t0, "mul_t0");
    add(m_ir, 1, f_t1, "mul_t1");
    add(m_ir, 1, f_t2, "mul_t2");
    add(m_ir, 1, ob(S_YIN, 1, 0, 0, 16'h0010), "mul_t3");
    add(m_ir, 1, ob(S_ZIN, 1, 5'b01111, 0, 16'h0004), "mul_t4");
    add(m_ir, 1, ob(S_ZLO | S_LOIN, 1, 0, 0, 0), "mul_t5");
    add(m_ir, 1, ob(S_ZHI | S_HIIN, 1, 0, 0, 0), "mul_t6");
    // undefined opcode behaves as nop
    add(u_ir, 1, f_t0, "undef_t0");
    add(u_ir, 1, f_t1, "undef_t1");
    add(u_ir, 1, f_t2, "undef_t2");
    add(u_ir, 1, rst_o, "undef_t3");

    @(negedge Clock);
    #1 check(rst_o, "reset_hold");
    @(negedge Clock);
    Resetn = 1'b1;
    #1 check(rst_o, "rst_state");
    run_table();

    // halt, then stay halted, then a reset pulse restarts fetch
    add(h_ir, 1, f_t0, "halt_t0");
    add(h_ir, 1, f_t1, "halt_t1");
    add(h_ir, 1, f_t2, "halt_t2");
    add(h_ir, 1, rst_o, "halt_t3");
    for (int i = 0; i < 12; i++) add(h_ir, 1'($urandom_range(0, 1)), 52'h0, "halted");
    run_table();
    @(negedge Clock);
    Resetn = 1'b0;
    #1 check(rst_o, "halt_reset");
    @(negedge Clock);
    Resetn = 1'b1;
    #1 check(rst_o, "halt_rst_state");
    add(a_ir, 1, f_t0, "after_halt_t0");
    run_table();

    // reset asserted mid-T4 clears outputs before the next edge
    add(a_ir, 1, f_t1, "mid_t1");
    add(a_ir, 1, f_t2, "mid_t2");
    add(a_ir, 1, ob(S_YIN, 1, 0, 0, 16'h0004), "mid_t3");
    add(a_ir, 1, ob(S_ZIN, 1, 5'b00111, 0, 16'h0008), "mid_t4");
    run_table();
    #1 Resetn = 1'b0;
    #1 check(rst_o, "mid_t4_async_reset");
    @(negedge Clock);
    Resetn = 1'b1;
    #1 check(rst_o, "mid_rst_state");

    // randomized instruction stream against the reference model
    for (int n = 0; n < 60; n++) begin
      rnd = $urandom();
      case ($urandom_range(0, 3))
        0: op = 5'($urandom_range(3, 8));
        1: op = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'd16;
        2: op = 5'd26;
        default: op = 5'($urandom_range(0, 31));
      endcase
      if (op == 5'd27) op = 5'd26;
      rnd[31:27] = op;
      model_instr(rnd, $urandom_range(0, 3), 1'b1);
    end
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
